// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - coin values, credit width and state/change encodings for the coin accumulator
package coin_pkg;

  localparam int CREDIT_W = 10;
  localparam int NICKEL   = 5;
  localparam int DIME     = 10;
  localparam int QUARTER  = 25;
  localparam int DOLLAR   = 100;

  typedef enum logic [1:0] {IDLE, CHG_SEL, CHG_PULSE, CHG_GAP} state_t;
  typedef enum logic [1:0] {CH_NONE, CH_NICKEL, CH_DIME, CH_QUARTER} change_t;

  // ev bit order: {dollar, quarter, dime, nickel}; callers reject multi-coin cycles first
  function automatic logic [6:0] coin_value(input logic [3:0] ev);
    if (ev[3])      return 7'(DOLLAR);
    else if (ev[2]) return 7'(QUARTER);
    else if (ev[1]) return 7'(DIME);
    else if (ev[0]) return 7'(NICKEL);
    else            return 7'd0;
  endfunction

  function automatic logic [CREDIT_W-1:0] change_value(input change_t c);
    unique case (c)
      CH_QUARTER: return CREDIT_W'(QUARTER);
      CH_DIME:    return CREDIT_W'(DIME);
      CH_NICKEL:  return CREDIT_W'(NICKEL);
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/coin_edge_det.sv
// rtl/coin_edge_det.sv - registered rising-edge detector with sync reset
module coin_edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev;
  logic         armed;

  // armed masks the first cycle after reset so a level already high is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= '0;
      armed <= 1'b0;
    end else begin
      prev  <= din;
      armed <= 1'b1;
    end
  end

  assign rise = din & ~prev & {W{armed}};

endmodule

// File: rtl/coin_accumulator.sv
// rtl/coin_accumulator.sv - coin credit accumulator with vend deduction and paced greedy change return
module coin_accumulator
  import coin_pkg::*;
#(
  parameter int MAX_CREDIT  = 995,
  parameter int AUTO_CHANGE = 1,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_nickel,
  input  logic                coin_dime,
  input  logic                coin_quarter,
  input  logic                coin_dollar,
  input  logic                refund,
  input  logic                vend_done,
  input  logic [CREDIT_W-1:0] vend_price,
  output logic [CREDIT_W-1:0] moneyin,
  output logic                coin_reject,
  output logic                vend_err,
  output logic                change_busy,
  output logic                change_quarter,
  output logic                change_dime,
  output logic                change_nickel
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  logic [4:0]          ev;
  logic [3:0]          coin_ev;
  logic                refund_ev;
  logic                multi;

  state_t              state, state_n;
  change_t             sel, sel_n;
  logic [CREDIT_W-1:0] credit, credit_n, after_vend;
  logic [3:0]          gap_cnt, gap_n;
  logic                reject_n, err_n, vend_ok;
  logic [CREDIT_W:0]   sum;

  coin_edge_det #(.W(5)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  ({refund, coin_dollar, coin_quarter, coin_dime, coin_nickel}),
    .rise (ev)
  );

  assign coin_ev   = ev[3:0];
  assign refund_ev = ev[4];
  assign multi     = (coin_ev & (coin_ev - 4'd1)) != 4'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= CH_NONE;
      credit      <= '0;
      gap_cnt     <= '0;
      coin_reject <= 1'b0;
      vend_err    <= 1'b0;
    end else begin
      state       <= state_n;
      sel         <= sel_n;
      credit      <= credit_n;
      gap_cnt     <= gap_n;
      coin_reject <= reject_n;
      vend_err    <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    credit_n   = credit;
    gap_n      = gap_cnt;
    reject_n   = 1'b0;
    err_n      = 1'b0;
    vend_ok    = 1'b0;
    after_vend = credit;
    sum        = '0;

    // while change is being paid out, every coin and vend is refused
    if (state != IDLE) begin
      reject_n = |coin_ev;
      err_n    = vend_done;
    end

    unique case (state)
      IDLE: begin
        if (vend_done) begin
          if (vend_price <= credit) begin
            after_vend = credit - vend_price;
            vend_ok    = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
        credit_n = after_vend;
        sum      = {1'b0, after_vend} + {4'b0, coin_value(coin_ev)};
        if (multi) begin
          reject_n = 1'b1;
        end else if (|coin_ev) begin
          if (sum <= (CREDIT_W+1)'(MAX_CREDIT)) credit_n = sum[CREDIT_W-1:0];
          else                                  reject_n = 1'b1;
        end
        if ((refund_ev || ((AUTO_CHANGE != 0) && vend_ok)) && (credit_n != '0))
          state_n = CHG_SEL;
      end
      CHG_SEL: begin
        state_n = CHG_PULSE;
        if (credit >= CREDIT_W'(QUARTER))     sel_n = CH_QUARTER;
        else if (credit >= CREDIT_W'(DIME))   sel_n = CH_DIME;
        else if (credit >= CREDIT_W'(NICKEL)) sel_n = CH_NICKEL;
        else begin
          // sub-nickel residue cannot be paid out and is dropped
          sel_n    = CH_NONE;
          credit_n = '0;
          state_n  = IDLE;
        end
      end
      CHG_PULSE: begin
        credit_n = credit - change_value(sel);
        gap_n    = '0;
        state_n  = CHG_GAP;
      end
      CHG_GAP: begin
        if (gap_cnt == GAP_LAST) state_n = (credit != '0) ? CHG_SEL : IDLE;
        else                     gap_n   = gap_cnt + 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign moneyin        = credit;
  assign change_busy    = (state != IDLE);
  assign change_quarter = (state == CHG_PULSE) && (sel == CH_QUARTER);
  assign change_dime    = (state == CHG_PULSE) && (sel == CH_DIME);
  assign change_nickel  = (state == CHG_PULSE) && (sel == CH_NICKEL);

endmodule

// File: tb/tb_coin_accumulator.sv
// tb/tb_coin_accumulator.sv - self-checking bench for coin_accumulator with randomized credit model
module tb_coin_accumulator;

  localparam int GAP = 2;
  localparam int MAXC = 995;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_nickel, coin_dime, coin_quarter, coin_dollar;
  logic       refund, vend_done;
  logic [9:0] vend_price;
  logic [9:0] moneyin;
  logic       coin_reject, vend_err, change_busy;
  logic       change_quarter, change_dime, change_nickel;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  coin_accumulator #(.MAX_CREDIT(MAXC), .AUTO_CHANGE(1), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .coin_nickel(coin_nickel), .coin_dime(coin_dime),
    .coin_quarter(coin_quarter), .coin_dollar(coin_dollar),
    .refund(refund), .vend_done(vend_done), .vend_price(vend_price),
    .moneyin(moneyin), .coin_reject(coin_reject), .vend_err(vend_err),
    .change_busy(change_busy), .change_quarter(change_quarter),
    .change_dime(change_dime), .change_nickel(change_nickel)
  );

  // coins = {dollar, quarter, dime, nickel}; events happen in one cycle, results sampled the next
  task automatic do_cycle(input logic [3:0] coins, input logic rf, input logic vd, input int price,
                          output int m, output logic rej, output logic err, output logic busy);
    @(posedge clk); #1;
    {coin_dollar, coin_quarter, coin_dime, coin_nickel} = coins;
    refund = rf; vend_done = vd; vend_price = 10'(price);
    @(posedge clk); #1;
    {coin_dollar, coin_quarter, coin_dime, coin_nickel} = 4'b0;
    refund = 1'b0; vend_done = 1'b0;
    @(negedge clk);
    m = int'(moneyin); rej = coin_reject; err = vend_err; busy = change_busy;
  endtask

  // follows a change sequence from its selection cycle to the first idle cycle
  task automatic drain(input string tag, input int start);
    int c, low, mon, v, cyc;
    int exp_q[$];
    int got[$];
    bit done;
    logic [2:0] p;
    c = start;
    while (c >= 5) begin
      v = (c >= 25) ? 25 : (c >= 10) ? 10 : 5;
      exp_q.push_back(v);
      c -= v;
    end
    n_checks++;
    if (change_busy !== 1'b1) begin
      n_errors++; $display("FAIL %s busy_start got %b want 1", tag, change_busy);
    end
    low = 0; mon = start; done = 0;
    for (cyc = 0; cyc < 1000 && !done; cyc++) begin
      @(negedge clk);
      if (change_busy !== 1'b1) done = 1;
      else begin
        p = {change_quarter, change_dime, change_nickel};
        if (p != 3'b000) begin
          v = p[2] ? 25 : (p[1] ? 10 : 5);
          n_checks++;
          if ($countones(p) != 1) begin
            n_errors++; $display("FAIL %s onehot got %b want one bit", tag, p);
          end
          if (got.size() > 0) begin
            n_checks++;
            if (low != GAP + 1) begin
              n_errors++; $display("FAIL %s gap got %0d want %0d", tag, low, GAP + 1);
            end
          end
          n_checks++;
          if (moneyin !== 10'(mon)) begin
            n_errors++; $display("FAIL %s moneyin_at_pulse got %0d want %0d", tag, moneyin, mon);
          end
          got.push_back(v); mon -= v; low = 0;
        end else low++;
      end
    end
    n_checks++;
    if (!done) begin
      n_errors++; $display("FAIL %s timeout got busy want idle within 1000 cycles", tag);
    end
    n_checks++;
    if (got.size() != exp_q.size()) begin
      n_errors++; $display("FAIL %s pulse_count got %0d want %0d", tag, got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got[i] != exp_q[i]) begin
        n_errors++; $display("FAIL %s coin[%0d] got %0d want %0d", tag, i, got[i], exp_q[i]);
      end
    end
    n_checks++;
    if (moneyin !== 10'd0) begin
      n_errors++; $display("FAIL %s final_moneyin got %0d want 0", tag, moneyin);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; coin_dollar = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (moneyin !== 10'd0 || change_busy !== 1'b0 || coin_reject !== 1'b0 || vend_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_outputs got m=%0d busy=%b rej=%b err=%b want 0", moneyin, change_busy, coin_reject, vend_err);
    end
    n_checks++;
    if ({change_quarter, change_dime, change_nickel} !== 3'b000) begin
      n_errors++; $display("FAIL reset_change got %b want 000", {change_quarter, change_dime, change_nickel});
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (moneyin !== 10'd0 || coin_reject !== 1'b0) begin
      n_errors++; $display("FAIL reset_held_sensor got m=%0d rej=%b want 0 0", moneyin, coin_reject);
    end
    @(posedge clk); #1 coin_dollar = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_coins();
    logic [3:0] seq [3];
    int exp_m [3];
    int m; logic rej, err, busy;
    seq = '{4'b0100, 4'b0100, 4'b1000};
    exp_m = '{25, 50, 150};
    for (int i = 0; i < 3; i++) begin
      do_cycle(seq[i], 1'b0, 1'b0, 0, m, rej, err, busy);
      n_checks++;
      if (m != exp_m[i] || rej !== 1'b0) begin
        n_errors++; $display("FAIL coins[%0d] got m=%0d rej=%b want m=%0d rej=0", i, m, rej, exp_m[i]);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_vend_auto_change();
    int m; logic rej, err, busy;
    do_cycle(4'b0, 1'b0, 1'b1, 125, m, rej, err, busy);
    n_checks++;
    if (m != 25 || err !== 1'b0 || busy !== 1'b1) begin
      n_errors++; $display("FAIL vend_accept got m=%0d err=%b busy=%b want 25 0 1", m, err, busy);
    end
    drain("vend_change", 25);
  endtask

  task automatic test_refund_greedy();
    int m; logic rej, err, busy;
    do_cycle(4'b0001, 1'b0, 1'b0, 0, m, rej, err, busy);
    do_cycle(4'b0010, 1'b0, 1'b0, 0, m, rej, err, busy);
    do_cycle(4'b0100, 1'b0, 1'b0, 0, m, rej, err, busy);
    n_checks++;
    if (m != 40) begin
      n_errors++; $display("FAIL refund_setup got %0d want 40", m);
    end
    do_cycle(4'b0, 1'b1, 1'b0, 0, m, rej, err, busy);
    n_checks++;
    if (busy !== 1'b1 || m != 40) begin
      n_errors++; $display("FAIL refund_start got busy=%b m=%0d want 1 40", busy, m);
    end
    drain("refund40", 40);
  endtask

  task automatic test_limits();
    logic [3:0] top_up [4];
    int exp_m [4];
    logic exp_rej [4];
    int m; logic rej, err, busy;
    for (int i = 0; i < 9; i++) do_cycle(4'b1000, 1'b0, 1'b0, 0, m, rej, err, busy);
    for (int i = 0; i < 2; i++) do_cycle(4'b0100, 1'b0, 1'b0, 0, m, rej, err, busy);
    n_checks++;
    if (m != 950) begin
      n_errors++; $display("FAIL limit_setup got %0d want 950", m);
    end
    do_cycle(4'b1000, 1'b0, 1'b0, 0, m, rej, err, busy);
    n_checks++;
    if (m != 950 || rej !== 1'b1) begin
      n_errors++; $display("FAIL over_max got m=%0d rej=%b want 950 1", m, rej);
    end
    do_cycle(4'b0011, 1'b0, 1'b0, 0, m, rej, err, busy);
    n_checks++;
    if (m != 950 || rej !== 1'b1) begin
      n_errors++; $display("FAIL two_coins got m=%0d rej=%b want 950 1", m, rej);
    end
    @(negedge clk);
    n_checks++;
    if (coin_reject !== 1'b0) begin
      n_errors++; $display("FAIL reject_width got %b want 0", coin_reject);
    end
    top_up = '{4'b0100, 4'b0010, 4'b0010, 4'b0001};
    exp_m = '{975, 985, 995, 995};
    exp_rej = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      do_cycle(top_up[i], 1'b0, 1'b0, 0, m, rej, err, busy);
      n_checks++;
      if (m != exp_m[i] || rej !== exp_rej[i]) begin
        n_errors++; $display("FAIL max_edge[%0d] got m=%0d rej=%b want %0d %b", i, m, rej, exp_m[i], exp_rej[i]);
      end
    end
    do_cycle(4'b0, 1'b1, 1'b0, 0, m, rej, err, busy);
    drain("refund995", 995);
  endtask

  task automatic test_vend_err_and_busy_coin();
    int m; logic rej, err, busy;
    do_cycle(4'b0100, 1'b0, 1'b0, 0, m, rej, err, busy);
    do_cycle(4'b0100, 1'b0, 1'b0, 0, m, rej, err, busy);
    do_cycle(4'b0, 1'b0, 1'b1, 75, m, rej, err, busy);
    n_checks++;
    if (m != 50 || err !== 1'b1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL vend_err got m=%0d err=%b busy=%b want 50 1 0", m, err, busy);
    end
    do_cycle(4'b0, 1'b1, 1'b0, 0, m, rej, err, busy);
    fork
      drain("busy_coin", 50);
      begin
        repeat (3) @(posedge clk);
        #1 coin_dime = 1'b1;
        @(posedge clk); #1 coin_dime = 1'b0;
        @(negedge clk);
        n_checks++;
        if (coin_reject !== 1'b1) begin
          n_errors++; $display("FAIL busy_coin_reject got %b want 1", coin_reject);
        end
      end
    join
  endtask

  task automatic test_reset_mid_change();
    int m, cyc, pulses; logic rej, err, busy;
    do_cycle(4'b1000, 1'b0, 1'b0, 0, m, rej, err, busy);
    do_cycle(4'b0, 1'b1, 1'b0, 0, m, rej, err, busy);
    cyc = 0;
    while (change_quarter !== 1'b1 && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    n_checks++;
    if (cyc >= 20) begin
      n_errors++; $display("FAIL mid_reset_first_pulse got none want change_quarter within 20 cycles");
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (moneyin !== 10'd0 || change_busy !== 1'b0) begin
      n_errors++; $display("FAIL mid_reset got m=%0d busy=%b want 0 0", moneyin, change_busy);
    end
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (change_quarter || change_dime || change_nickel) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_errors++; $display("FAIL mid_reset_no_pulses got %0d want 0", pulses);
    end
  endtask

  task automatic test_random();
    int vals [4];
    int credit, c, price, op, i, j, v, nc, m;
    logic [3:0] coins;
    logic rf, vd, acc, exp_rej, exp_err, trig, rej, err, busy;
    vals = '{5, 10, 25, 100};
    credit = 0;
    for (int k = 0; k < 80; k++) begin
      coins = 4'b0; rf = 1'b0; vd = 1'b0; price = 0;
      op = $urandom_range(0, 9);
      if (op <= 5) coins[$urandom_range(0, 3)] = 1'b1;
      else if (op == 6) begin
        i = $urandom_range(0, 3);
        j = (i + 1 + $urandom_range(0, 2)) % 4;
        coins[i] = 1'b1; coins[j] = 1'b1;
      end else if (op <= 8) begin
        vd = 1'b1;
        price = $urandom_range(0, credit + 40);
        if (price > 1023) price = 1023;
        if ($urandom_range(0, 1) == 1) coins[$urandom_range(0, 3)] = 1'b1;
      end else rf = 1'b1;

      c = credit; acc = 1'b0; exp_rej = 1'b0; exp_err = 1'b0;
      if (vd) begin
        if (price <= c) begin c -= price; acc = 1'b1; end
        else exp_err = 1'b1;
      end
      nc = $countones(coins);
      if (nc > 1) exp_rej = 1'b1;
      else if (nc == 1) begin
        v = 0;
        for (int b = 0; b < 4; b++) if (coins[b]) v = vals[b];
        if (c + v <= MAXC) c += v;
        else exp_rej = 1'b1;
      end
      trig = (rf || acc) && (c != 0);

      do_cycle(coins, rf, vd, price, m, rej, err, busy);
      n_checks++;
      if (m != c || rej !== exp_rej || err !== exp_err || busy !== trig) begin
        n_errors++;
        $display("FAIL random[%0d] got m=%0d rej=%b err=%b busy=%b want m=%0d rej=%b err=%b busy=%b",
                 k, m, rej, err, busy, c, exp_rej, exp_err, trig);
      end
      if (trig) begin
        drain("random_change", c);
        credit = 0;
      end else credit = c;
    end
  endtask

  initial begin
    rst = 1'b1;
    coin_nickel = 1'b0; coin_dime = 1'b0; coin_quarter = 1'b0; coin_dollar = 1'b0;
    refund = 1'b0; vend_done = 1'b0; vend_price = 10'd0;
    test_reset();
    test_coins();
    test_vend_auto_change();
    test_refund_greedy();
    test_limits();
    test_vend_err_and_busy_coin();
    test_reset_mid_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog got no finish want finish within 80000 cycles");
    $fatal(1);
  end

endmodule
